// File: rtl/hwag_tooth_sync.sv
// rtl/hwag_tooth_sync.sv - HWAG tooth sequencer: period capture, gap detection, search/verify/sync FSM
// The edge input is named edge_pulse because 'edge' is a reserved SystemVerilog keyword.
module hwag_tooth_sync #(
  parameter int PCNT_WIDTH = 24,
  parameter int TCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  edge_pulse,
  input  logic [TCNT_WIDTH-1:0] tooth_num,
  output logic                  cap_run_ena,
  output logic                  sync,
  output logic [TCNT_WIDTH-1:0] tcnt,
  output logic [PCNT_WIDTH-1:0] pcnt_last,
  output logic                  gap_det,
  output logic                  sync_err,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_MEAS   = 3'd2,
    S_SEARCH = 3'd3,
    S_VERIFY = 3'd4,
    S_SYNC   = 3'd5
  } state_t;

  localparam logic [PCNT_WIDTH-1:0] PCNT_MAX = '1;

  state_t                  state_q, state_d;
  logic [PCNT_WIDTH-1:0]   pcnt, pcnt_d, pcnt_last_d;
  logic [TCNT_WIDTH-1:0]   tcnt_d, tn_last;
  logic                    sync_d, gap_det_d, sync_err_d, cap_run_ena_d;
  logic                    is_gap, timeout, tracking;

  assign tn_last  = tooth_num - TCNT_WIDTH'(1);
  // Doubling pcnt_last needs one extra bit so large periods cannot wrap.
  assign is_gap   = {1'b0, pcnt} > {pcnt_last, 1'b0};
  assign tracking = (state_q == S_MEAS) || (state_q == S_SEARCH) ||
                    (state_q == S_VERIFY) || (state_q == S_SYNC);
  assign timeout  = tracking && (pcnt == PCNT_MAX);

  always_comb begin
    state_d     = state_q;
    pcnt_d      = (pcnt == PCNT_MAX) ? pcnt : pcnt + PCNT_WIDTH'(1);
    pcnt_last_d = pcnt_last;
    tcnt_d      = tcnt;
    sync_d      = sync;
    gap_det_d   = 1'b0;
    sync_err_d  = 1'b0;

    if (!start) begin
      state_d = S_IDLE;
      pcnt_d  = '0;
      tcnt_d  = '0;
      sync_d  = 1'b0;
    end else if (state_q == S_IDLE) begin
      pcnt_d  = '0;
      state_d = S_FIRST;
    end else if (timeout) begin
      // A coincident edge is dropped; the wheel has stalled or lost its signal.
      sync_err_d = 1'b1;
      sync_d     = 1'b0;
      tcnt_d     = '0;
      state_d    = S_FIRST;
    end else if (edge_pulse) begin
      pcnt_last_d = pcnt;
      pcnt_d      = PCNT_WIDTH'(1);
      unique case (state_q)
        S_FIRST: state_d = S_MEAS;
        S_MEAS:  state_d = S_SEARCH;
        S_SEARCH: begin
          tcnt_d = '0;
          if (is_gap) begin
            gap_det_d = 1'b1;
            state_d   = S_VERIFY;
          end
        end
        S_VERIFY, S_SYNC: begin
          if (is_gap) begin
            gap_det_d = 1'b1;
            tcnt_d    = '0;
            if (tcnt == tn_last) begin
              sync_d  = 1'b1;
              state_d = S_SYNC;
            end else begin
              // In VERIFY a misplaced gap simply becomes the new reference.
              sync_err_d = 1'b1;
              sync_d     = 1'b0;
              state_d    = (state_q == S_SYNC) ? S_SEARCH : S_VERIFY;
            end
          end else if (tcnt >= tn_last) begin
            sync_err_d = 1'b1;
            sync_d     = 1'b0;
            tcnt_d     = '0;
            state_d    = S_SEARCH;
          end else begin
            tcnt_d = tcnt + TCNT_WIDTH'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign cap_run_ena_d = (state_d != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pcnt        <= '0;
      pcnt_last   <= '0;
      tcnt        <= '0;
      sync        <= 1'b0;
      gap_det     <= 1'b0;
      sync_err    <= 1'b0;
      cap_run_ena <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt        <= pcnt_d;
      pcnt_last   <= pcnt_last_d;
      tcnt        <= tcnt_d;
      sync        <= sync_d;
      gap_det     <= gap_det_d;
      sync_err    <= sync_err_d;
      cap_run_ena <= cap_run_ena_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hwag_tooth_sync.sv
// tb/tb_hwag_tooth_sync.sv - self-checking bench for hwag_tooth_sync with a per-edge reference model
module tb_hwag_tooth_sync;
  localparam int PW = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          edge_pulse = 1'b0;
  logic [TW-1:0] tooth_num = 8'd58;
  logic          cap_run_ena, sync, gap_det, sync_err;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] pcnt_last;
  logic [2:0]    state;

  hwag_tooth_sync #(.PCNT_WIDTH(PW), .TCNT_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .edge_pulse(edge_pulse), .tooth_num(tooth_num),
    .cap_run_ena(cap_run_ena), .sync(sync), .tcnt(tcnt), .pcnt_last(pcnt_last),
    .gap_det(gap_det), .sync_err(sync_err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Reference model: wheel position expressed as teeth seen since the last accepted gap.
  int m_state = 0, m_tcnt = 0, m_sync = 0, m_last = 0, m_gap = 0, m_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit chk_pl);
    chk({tag, ".state"}, 32'(state), m_state);
    chk({tag, ".tcnt"}, 32'(tcnt), m_tcnt);
    chk({tag, ".sync"}, 32'(sync), m_sync);
    chk({tag, ".gap_det"}, 32'(gap_det), m_gap);
    chk({tag, ".sync_err"}, 32'(sync_err), m_err);
    chk({tag, ".cap_run_ena"}, 32'(cap_run_ena), (m_state != 0) ? 1 : 0);
    if (chk_pl) chk({tag, ".pcnt_last"}, 32'(pcnt_last), m_last);
  endtask

  task automatic model_edge(input int n);
    int tn;
    tn = int'(tooth_num);
    m_gap = 0;
    m_err = 0;
    case (m_state)
      1: m_state = 2;
      2: m_state = 3;
      3: if (n > 2 * m_last) begin m_gap = 1; m_tcnt = 0; m_state = 4; end
      4, 5: begin
        if (n > 2 * m_last) begin
          m_gap = 1;
          if (m_tcnt == tn - 1) begin
            m_tcnt = 0; m_sync = 1; m_state = 5;
          end else begin
            m_err = 1; m_tcnt = 0;
            if (m_state == 5) begin m_sync = 0; m_state = 3; end
          end
        end else if (m_tcnt + 1 > tn - 1) begin
          m_err = 1; m_tcnt = 0; m_sync = 0; m_state = 3;
        end else begin
          m_tcnt++;
        end
      end
      default: ;
    endcase
    m_last = n;
  endtask

  // Edge pulses are exactly n clocks apart, so the captured period is n.
  task automatic send_edge(input int n);
    bit was_first;
    was_first = (m_state == 1);
    repeat (n - 1) begin
      tick();
      chk("idle.pulses", 32'({gap_det, sync_err}), 0);
    end
    edge_pulse = 1'b1;
    tick();
    edge_pulse = 1'b0;
    model_edge(n);
    check_all("edge", !was_first);
  endtask

  task automatic rev(input int p, input int teeth);
    send_edge(3 * p);
    repeat (teeth) send_edge(p);
  endtask

  initial begin
    int p, k, r;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1);
    rst = 1'b0;

    start = 1'b1;
    tick();
    m_state = 1;
    check_all("start", 0);

    // 60-2 wheel scaled to fit an 8-bit period counter.
    repeat (5) send_edge(40);
    repeat (3) rev(40, 57);
    send_edge(120);
    chk("wheel.synced", 32'(sync), 1);

    // One revolution with an extra tooth, then resync.
    repeat (58) send_edge(40);
    chk("extra.state", 32'(state), 3);
    repeat (2) rev(40, 57);
    send_edge(120);

    // Edges stop: timeout 255 clocks after the last edge.
    repeat (254) begin
      tick();
      chk("to.wait", 32'(sync_err), 0);
    end
    tick();
    m_err = 1; m_gap = 0; m_sync = 0; m_tcnt = 0; m_state = 1;
    check_all("timeout", 1);
    tick();
    chk("to.pulse_end", 32'(sync_err), 0);
    send_edge(50);
    chk("to.pl_saturated", 32'(pcnt_last), 255);
    send_edge(40);
    repeat (2) rev(40, 57);
    send_edge(120);

    // start dropped in the same cycle as an edge.
    edge_pulse = 1'b1;
    start = 1'b0;
    tick();
    edge_pulse = 1'b0;
    m_state = 0; m_sync = 0; m_tcnt = 0; m_gap = 0; m_err = 0;
    check_all("stop", 1);
    start = 1'b1;
    tick();
    m_state = 1;
    check_all("restart", 0);

    // Even spacing never produces a gap.
    repeat (500) send_edge(40);

    // Random wheels with occasional extra or missing teeth.
    repeat (30) begin
      tooth_num = TW'($urandom_range(3, 12));
      p = $urandom_range(20, 70);
      k = int'(tooth_num) - 1;
      r = $urandom_range(0, 5);
      if (r == 0) k++;
      else if (r == 1) k--;
      rev(p, k);
    end

    // Settle into SYNC, then assert reset between clock edges.
    tooth_num = 8'd6;
    send_edge(40);
    repeat (3) rev(40, 5);
    chk("pre_rst.sync", 32'(sync), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    m_state = 0; m_sync = 0; m_tcnt = 0; m_gap = 0; m_err = 0; m_last = 0;
    check_all("async_rst", 1);
    #2;
    rst = 1'b0;
    tick();
    m_state = 1;
    check_all("post_rst", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hwag_tooth_sync.md
Name: hwag_tooth_sync

Overview:
Sequencer for the VR capture datapath of the hardware angle generator (HWAG).
- Consumes the filtered single-cycle edge pulse from the capture/filter stage.
- Measures tooth periods and locates the missing-tooth gap of the trigger wheel.
- Tracks the tooth index and runs a search/verify/sync state machine.
- Drives the capture run-enable and the sync status that downstream angle logic and the ssram status registers consume.

Parameters:
PCNT_WIDTH, 24, width of the tooth period counter and period registers (clock cycles).
TCNT_WIDTH, 8, width of the tooth counter and of the tooth_num configuration.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  run enable (level) from the control register; 0 forces IDLE
edge  input  1  single-cycle pulse, one per filtered tooth edge
tooth_num  input  TCNT_WIDTH  physical teeth per revolution (e.g. 58 for a 60-2 wheel); legal range 2..2^TCNT_WIDTH-1, sampled when used
cap_run_ena  output  1  capture enable for the filter/edge stage
sync  output  1  wheel synchronised
tcnt  output  TCNT_WIDTH  current tooth index, 0 = first tooth after the gap
pcnt_last  output  PCNT_WIDTH  last captured tooth period
gap_det  output  1  one-cycle pulse on an edge classified as gap
sync_err  output  1  one-cycle pulse on tooth-count mismatch or timeout
state  output  3  FSM state: IDLE=0, FIRST=1, MEAS=2, SEARCH=3, VERIFY=4, SYNC=5

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, internal pcnt and pcnt_prev set to 0.
- All registers update on posedge clk. Outputs are registered and reflect an edge one cycle after the edge pulse.
- Period counter pcnt:
  - On an edge: captures pcnt into pcnt_last, moves the old pcnt_last into pcnt_prev, and loads pcnt<=1.
  - Otherwise pcnt increments, saturating at all-ones.
  - Edges N clocks apart therefore capture the value N.
- Timeout: pcnt reaching all-ones in MEAS, SEARCH, VERIFY or SYNC pulses sync_err, clears sync and tcnt, and moves to FIRST.
- Gap classification, evaluated on an edge in SEARCH, VERIFY or SYNC:
  - Rule: gap when pcnt > 2*pcnt_last.
  - Compare at PCNT_WIDTH+1 bits with no overflow.
  - pcnt_last is the previous period before this edge's update.
- FSM transitions:
  - IDLE: cap_run_ena=0, pcnt held at 0. When start=1, go to FIRST.
  - FIRST: cap_run_ena=1, pcnt runs but has no valid period yet. On edge, go to MEAS.
  - MEAS: on edge (first valid period captured), go to SEARCH.
  - SEARCH: on a gap edge, pulse gap_det, set tcnt=0, go to VERIFY. On a normal edge, tcnt is don't-care and held at 0.
  - VERIFY, normal edge: tcnt++. If tcnt would exceed tooth_num-1, pulse sync_err and go to SEARCH.
  - VERIFY, gap edge: pulse gap_det. If tcnt==tooth_num-1, set sync=1, tcnt=0, go to SYNC. Otherwise pulse sync_err, set tcnt=0, stay in VERIFY (this gap is the new reference).
  - SYNC: same tooth-count checks as VERIFY. On mismatch, pulse sync_err, set sync=0, go to SEARCH. A gap edge with tcnt==tooth_num-1 keeps sync and sets tcnt=0.
- start=0 in any state: go to IDLE next cycle, clear sync/tcnt/pcnt. An edge in that same cycle is ignored.
- Priority: start=0 > timeout > edge.
- An edge coincident with pcnt saturation is treated as timeout, and the edge is discarded.
- tooth_num change mid-run takes effect at the next comparison; no resync is forced.

Test Plan:
- Reset mid-SYNC (rst pulsed asynchronously between clock edges) -> all outputs 0 immediately; state=IDLE before the next clk edge.
- start=1; 60-2 wheel: 58 edges at 100-clk spacing, gap at 300 clk, repeated -> state sequence FIRST, MEAS, SEARCH, VERIFY at first gap (gap_det, tcnt=0); sync=1 at second gap; pcnt_last=100 on teeth, 300 on gap; tcnt cycles 0..57.
- In SYNC, one revolution with 59 teeth (one extra edge before the gap) -> sync_err when tcnt would reach 58; sync=0; state=SEARCH; resync after two more clean gaps.
- Equal spacing, 100 clk, no gap, for 500 edges -> never leaves SEARCH; gap_det, sync and sync_err stay 0.
- PCNT_WIDTH=8, edges stop in SYNC -> sync_err pulses 255 clk after the last edge; sync=0; state=FIRST; next edge goes to MEAS.
- start deasserted in SYNC in the same cycle as an edge -> state=IDLE; sync=0; tcnt=0; cap_run_ena=0; pcnt_last unchanged; no gap_det or sync_err.
